// File: rtl/sprite_frame_engine_pkg.sv
// Shared types and defaults for the sprite frame engine: FSM encoding, colour width,
// default playfield size and erase colour.
package sprite_pkg;

  localparam int COLOUR_W = 3;
  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;
  localparam logic [COLOUR_W-1:0] DEF_BG_COLOUR = 3'b000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ERASE,
    S_MOVE,
    S_DRAW,
    S_DONE
  } state_t;

endpackage

// File: rtl/sprite_frame_engine_rect_scanner.sv
// Walks a w x h rectangle one pixel per accepted plot (col inner, row outer);
// done_o marks the acceptance of the final pixel.
module rect_scanner #(
  parameter int SIZE_W = 6
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [SIZE_W-1:0] w_i,
  input  logic [SIZE_W-1:0] h_i,
  input  logic              ready_i,
  output logic              plot_o,
  output logic [SIZE_W-1:0] col_o,
  output logic [SIZE_W-1:0] row_o,
  output logic              done_o
);

  logic              active_q;
  logic [SIZE_W-1:0] col_q, row_q, w_q, h_q;
  logic              last_col, last_row;

  assign last_col = (col_q == SIZE_W'(w_q - 1'b1));
  assign last_row = (row_q == SIZE_W'(h_q - 1'b1));
  assign plot_o   = active_q;
  assign col_o    = col_q;
  assign row_o    = row_q;
  assign done_o   = active_q && ready_i && last_col && last_row;

  // Size is latched at start so a mid-pass change of w/h cannot corrupt the count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
      w_q      <= '0;
      h_q      <= '0;
    end else if (start_i) begin
      active_q <= 1'b1;
      col_q    <= '0;
      row_q    <= '0;
      w_q      <= w_i;
      h_q      <= h_i;
    end else if (active_q && ready_i) begin
      if (last_col) begin
        col_q <= '0;
        if (last_row) active_q <= 1'b0;
        else          row_q    <= row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_frame_engine.sv
// N-sprite frame engine: per frame, wait, then erase/move/draw each active slot.
// Define SPRITE_COLLIDE_EN to make bounce sprites reflect off player-mode sprites.
module sprite_frame_engine
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 3,
  parameter int COORD_W     = 10,
  parameter int SIZE_W      = 6,
  parameter int SCREEN_W    = DEF_SCREEN_W,
  parameter int SCREEN_H    = DEF_SCREEN_H,
  parameter int FRAME_TICKS = 400000,
  parameter logic [COLOUR_W-1:0] BG_COLOUR = DEF_BG_COLOUR
) (
  input  logic                            clock,
  input  logic                            resetn,
  input  logic                            run,
  input  logic [NUM_SPRITES-1:0]          ld,
  input  logic [COORD_W-1:0]              ld_x,
  input  logic [COORD_W-1:0]              ld_y,
  input  logic [NUM_SPRITES-1:0]          spr_en,
  input  logic [NUM_SPRITES-1:0]          spr_mode,
  input  logic [NUM_SPRITES*SIZE_W-1:0]   spr_w,
  input  logic [NUM_SPRITES*SIZE_W-1:0]   spr_h,
  input  logic [NUM_SPRITES*COLOUR_W-1:0] spr_col,
  input  logic [NUM_SPRITES-1:0]          btn_up,
  input  logic [NUM_SPRITES-1:0]          btn_dn,
  input  logic                            pix_ready,
  output logic [COORD_W-1:0]              x_out,
  output logic [COORD_W-1:0]              y_out,
  output logic [COLOUR_W-1:0]             colour_out,
  output logic                            plot,
  output logic                            busy,
  output logic                            frame_done,
  output logic [NUM_SPRITES-1:0]          hit_l,
  output logic [NUM_SPRITES-1:0]          hit_r
);

  localparam int SEL_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam int CNT_W = $clog2(FRAME_TICKS + 1);
  localparam int AW    = COORD_W + 2;
  localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(FRAME_TICKS - 1);
  localparam logic signed [AW-1:0] SCR_W    = AW'(SCREEN_W);
  localparam logic signed [AW-1:0] SCR_H    = AW'(SCREEN_H);

  state_t                     state_q;
  logic [SEL_W-1:0]           cur_q;
  logic [CNT_W-1:0]           cnt_q;
  logic                       scan_start_q, frame_done_q;

  logic [COORD_W-1:0]         pos_x_q [NUM_SPRITES];
  logic [COORD_W-1:0]         pos_y_q [NUM_SPRITES];
  logic [COORD_W-1:0]         pend_x_q [NUM_SPRITES];
  logic [COORD_W-1:0]         pend_y_q [NUM_SPRITES];
  logic [NUM_SPRITES-1:0]     dx_q, dy_q, pend_q, hit_l_q, hit_r_q;

  logic [SIZE_W-1:0]          w_a [NUM_SPRITES];
  logic [SIZE_W-1:0]          h_a [NUM_SPRITES];
  logic [COLOUR_W-1:0]        col_a [NUM_SPRITES];
  logic [NUM_SPRITES-1:0]     slot_act;

  logic                       first_ok, next_ok;
  logic [SEL_W-1:0]           first_sel, next_sel;

  logic                       scan_plot, scan_done;
  logic [SIZE_W-1:0]          scan_col, scan_row;

  logic [COORD_W-1:0]         pos_x_d, pos_y_d;
  logic                       dx_d, dy_d, hit_l_d, hit_r_d;
  logic signed [AW-1:0]       cx, cy, cw, ch, nx, ny, py_max;
`ifdef SPRITE_COLLIDE_EN
  logic                       collide;
  logic signed [AW-1:0]       yb;
`endif

  always_comb begin
    for (int i = 0; i < NUM_SPRITES; i++) begin
      w_a[i]      = spr_w[i*SIZE_W +: SIZE_W];
      h_a[i]      = spr_h[i*SIZE_W +: SIZE_W];
      col_a[i]    = spr_col[i*COLOUR_W +: COLOUR_W];
      slot_act[i] = spr_en[i] && (w_a[i] != '0) && (h_a[i] != '0);
    end
  end

  // Descending scan so the lowest-numbered qualifying slot wins.
  always_comb begin
    first_ok  = 1'b0;
    first_sel = '0;
    next_ok   = 1'b0;
    next_sel  = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (slot_act[i]) begin
        first_ok  = 1'b1;
        first_sel = SEL_W'(i);
        if (i > int'(cur_q)) begin
          next_ok  = 1'b1;
          next_sel = SEL_W'(i);
        end
      end
    end
  end

  always_comb begin
    cx      = $signed({2'b00, pos_x_q[cur_q]});
    cy      = $signed({2'b00, pos_y_q[cur_q]});
    cw      = $signed({{(AW-SIZE_W){1'b0}}, w_a[cur_q]});
    ch      = $signed({{(AW-SIZE_W){1'b0}}, h_a[cur_q]});
    nx      = dx_q[cur_q] ? cx + AW'(1) : cx - AW'(1);
    ny      = dy_q[cur_q] ? cy + AW'(1) : cy - AW'(1);
    py_max  = SCR_H - ch;
    pos_x_d = pos_x_q[cur_q];
    pos_y_d = pos_y_q[cur_q];
    dx_d    = dx_q[cur_q];
    dy_d    = dy_q[cur_q];
    hit_l_d = 1'b0;
    hit_r_d = 1'b0;
`ifdef SPRITE_COLLIDE_EN
    collide = 1'b0;
    yb      = '0;
`endif
    if (spr_mode[cur_q]) begin
      if (btn_up[cur_q] ^ btn_dn[cur_q]) begin
        ny = btn_up[cur_q] ? cy - AW'(1) : cy + AW'(1);
        if (ny > py_max) ny = py_max;
        if (ny < 0)      ny = '0;
        pos_y_d = ny[COORD_W-1:0];
      end
    end else begin
      if (ny < 0 || ny + ch > SCR_H) dy_d = ~dy_q[cur_q];
      else                           pos_y_d = ny[COORD_W-1:0];
`ifdef SPRITE_COLLIDE_EN
      yb = $signed({2'b00, pos_y_d});
      for (int j = 0; j < NUM_SPRITES; j++) begin
        if (j != int'(cur_q) && slot_act[j] && spr_mode[j] &&
            nx < $signed({2'b00, pos_x_q[j]}) + $signed({{(AW-SIZE_W){1'b0}}, w_a[j]}) &&
            $signed({2'b00, pos_x_q[j]}) < nx + cw &&
            yb < $signed({2'b00, pos_y_q[j]}) + $signed({{(AW-SIZE_W){1'b0}}, h_a[j]}) &&
            $signed({2'b00, pos_y_q[j]}) < yb + ch)
          collide = 1'b1;
      end
`endif
      if (nx < 0) begin
        dx_d    = ~dx_q[cur_q];
        hit_l_d = 1'b1;
      end else if (nx + cw > SCR_W) begin
        dx_d    = ~dx_q[cur_q];
        hit_r_d = 1'b1;
      end
`ifdef SPRITE_COLLIDE_EN
      else if (collide) begin
        dx_d = ~dx_q[cur_q];
      end
`endif
      else begin
        pos_x_d = nx[COORD_W-1:0];
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      cur_q        <= '0;
      cnt_q        <= CNT_LOAD;
      scan_start_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      scan_start_q <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q <= CNT_LOAD;
          if (run) state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            cnt_q <= CNT_LOAD;
            if (first_ok) begin
              cur_q        <= first_sel;
              state_q      <= S_ERASE;
              scan_start_q <= 1'b1;
            end else begin
              state_q      <= S_DONE;
              frame_done_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_ERASE: if (scan_done) state_q <= S_MOVE;
        S_MOVE: begin
          state_q      <= S_DRAW;
          scan_start_q <= 1'b1;
        end
        S_DRAW: begin
          if (scan_done) begin
            if (next_ok) begin
              cur_q        <= next_sel;
              state_q      <= S_ERASE;
              scan_start_q <= 1'b1;
            end else begin
              state_q      <= S_DONE;
              frame_done_q <= 1'b1;
            end
          end
        end
        S_DONE:  state_q <= run ? S_WAIT : S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Loads land immediately unless the slot is part of an in-flight frame; then they wait for its MOVE.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        pos_x_q[i]  <= '0;
        pos_y_q[i]  <= '0;
        pend_x_q[i] <= '0;
        pend_y_q[i] <= '0;
      end
      dx_q    <= '1;
      dy_q    <= '1;
      pend_q  <= '0;
      hit_l_q <= '0;
      hit_r_q <= '0;
    end else begin
      hit_l_q <= '0;
      hit_r_q <= '0;
      if (state_q == S_MOVE) begin
        if (pend_q[cur_q]) begin
          pos_x_q[cur_q] <= pend_x_q[cur_q];
          pos_y_q[cur_q] <= pend_y_q[cur_q];
          pend_q[cur_q]  <= 1'b0;
        end else begin
          pos_x_q[cur_q] <= pos_x_d;
          pos_y_q[cur_q] <= pos_y_d;
          dx_q[cur_q]    <= dx_d;
          dy_q[cur_q]    <= dy_d;
          hit_l_q[cur_q] <= hit_l_d;
          hit_r_q[cur_q] <= hit_r_d;
        end
      end
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (ld[i]) begin
          if (state_q == S_IDLE || !slot_act[i] ||
              (state_q == S_MOVE && cur_q == SEL_W'(i))) begin
            pos_x_q[i] <= ld_x;
            pos_y_q[i] <= ld_y;
            pend_q[i]  <= 1'b0;
          end else begin
            pend_q[i]   <= 1'b1;
            pend_x_q[i] <= ld_x;
            pend_y_q[i] <= ld_y;
          end
        end
      end
    end
  end

  rect_scanner #(.SIZE_W(SIZE_W)) u_scan (
    .clk_i   (clock),
    .rst_ni  (resetn),
    .start_i (scan_start_q),
    .w_i     (w_a[cur_q]),
    .h_i     (h_a[cur_q]),
    .ready_i (pix_ready),
    .plot_o  (scan_plot),
    .col_o   (scan_col),
    .row_o   (scan_row),
    .done_o  (scan_done)
  );

  assign plot       = scan_plot;
  assign x_out      = scan_plot ? pos_x_q[cur_q] + COORD_W'(scan_col) : '0;
  assign y_out      = scan_plot ? pos_y_q[cur_q] + COORD_W'(scan_row) : '0;
  assign colour_out = scan_plot ? ((state_q == S_DRAW) ? col_a[cur_q] : BG_COLOUR) : '0;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = frame_done_q;
  assign hit_l      = hit_l_q;
  assign hit_r      = hit_r_q;

endmodule

// File: tb/tb_sprite_frame_engine.sv
// Self-checking bench for sprite_frame_engine: table of single-frame motion cases
// plus multi-frame, stall, disabled-slot, pending-load and reset-abort sequences.
module tb_sprite_frame_engine;

  localparam int NS = 3;
  localparam int CW = 10;
  localparam int SW = 6;
  localparam int FT = 4;

  logic            clock = 1'b0;
  logic            resetn = 1'b0;
  logic            run = 1'b0;
  logic [NS-1:0]   ld = '0;
  logic [CW-1:0]   ld_x = '0, ld_y = '0;
  logic [NS-1:0]   spr_en = '0, spr_mode = '0;
  logic [NS*SW-1:0] spr_w = '0, spr_h = '0;
  logic [NS*3-1:0] spr_col = '0;
  logic [NS-1:0]   btn_up = '0, btn_dn = '0;
  logic            pix_ready = 1'b1;
  logic [CW-1:0]   x_out, y_out;
  logic [2:0]      colour_out;
  logic            plot, busy, frame_done;
  logic [NS-1:0]   hit_l, hit_r;

  sprite_frame_engine #(.NUM_SPRITES(NS), .COORD_W(CW), .SIZE_W(SW), .FRAME_TICKS(FT)) dut (
    .clock(clock), .resetn(resetn), .run(run), .ld(ld), .ld_x(ld_x), .ld_y(ld_y),
    .spr_en(spr_en), .spr_mode(spr_mode), .spr_w(spr_w), .spr_h(spr_h), .spr_col(spr_col),
    .btn_up(btn_up), .btn_dn(btn_dn), .pix_ready(pix_ready),
    .x_out(x_out), .y_out(y_out), .colour_out(colour_out), .plot(plot), .busy(busy),
    .frame_done(frame_done), .hit_l(hit_l), .hit_r(hit_r)
  );

  always #5 clock = ~clock;

  typedef struct { logic [CW-1:0] x; logic [CW-1:0] y; logic [2:0] c; } pix_t;
  typedef struct { int mode; int x; int y; int w; int h; int up; int dn; int ex; int ey; int hl; int hr; } vec_t;

  pix_t exp_q[$];
  int   checks = 0, passed = 0;
  int   cyc = 0, frames = 0, acc_cnt = 0, last_acc_cyc = 0, fd_cyc = 0;
  int   hitl_cnt[NS], hitr_cnt[NS];
  bit   rand_ready = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  always @(negedge clock) begin
    cyc++;
    if (resetn) begin
      if (frame_done) begin frames++; fd_cyc = cyc; end
      for (int s = 0; s < NS; s++) begin
        if (hit_l[s]) hitl_cnt[s]++;
        if (hit_r[s]) hitr_cnt[s]++;
      end
      if (plot) begin
        check("pix_pending", (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
          check("pix_x", int'(x_out), int'(exp_q[0].x));
          check("pix_y", int'(y_out), int'(exp_q[0].y));
          check("pix_colour", int'(colour_out), int'(exp_q[0].c));
          if (pix_ready) begin
            void'(exp_q.pop_front());
            acc_cnt++;
            last_acc_cyc = cyc;
          end
        end
      end
    end
  end

  always begin
    @(posedge clock);
    #1;
    if (rand_ready) pix_ready = ($urandom_range(0, 1) == 1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic do_reset();
    resetn = 1'b0; run = 1'b0; ld = '0; spr_en = '0; btn_up = '0; btn_dn = '0;
    tick(2);
    exp_q.delete();
    for (int s = 0; s < NS; s++) begin hitl_cnt[s] = 0; hitr_cnt[s] = 0; end
    resetn = 1'b1;
    tick(1);
  endtask

  task automatic set_slot(input int s, input int en, input int mode, input int w, input int h, input int col);
    spr_en[s]          = (en != 0);
    spr_mode[s]        = (mode != 0);
    spr_w[s*SW +: SW]  = SW'(w);
    spr_h[s*SW +: SW]  = SW'(h);
    spr_col[s*3 +: 3]  = 3'(col);
  endtask

  task automatic load(input int s, input int x, input int y);
    ld[s] = 1'b1; ld_x = CW'(x); ld_y = CW'(y);
    tick(1);
    ld = '0;
  endtask

  task automatic push_rect(input int x, input int y, input int w, input int h, input int c);
    pix_t p;
    for (int r = 0; r < h; r++)
      for (int k = 0; k < w; k++) begin
        p.x = CW'(x + k); p.y = CW'(y + r); p.c = 3'(c);
        exp_q.push_back(p);
      end
  endtask

  task automatic run_frame(input int ls = -1, input int lx = 0, input int ly = 0);
    int f0;
    f0 = frames;
    acc_cnt = 0;
    run = 1'b1;
    tick(1);
    run = 1'b0;
    if (ls >= 0) load(ls, lx, ly);
    for (int k = 0; k < 1000 && frames == f0; k++) tick(1);
    check("frame_done_seen", (frames > f0) ? 1 : 0, 1);
    tick(2);
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    vec_t tbl[10];
    tbl[0] = '{0,  10,  10, 2, 2, 0, 0,  11,  11, 0, 0};
    tbl[1] = '{0, 156,  20, 4, 2, 0, 0, 156,  21, 0, 1};
    tbl[2] = '{0,   0, 118, 3, 2, 0, 0,   1, 118, 0, 0};
    tbl[3] = '{0, 157,   5, 2, 1, 0, 0, 158,   6, 0, 0};
    tbl[4] = '{0, 158,   5, 2, 1, 0, 0, 158,   6, 0, 1};
    tbl[5] = '{1,  50, 112, 2, 8, 0, 1,  50, 112, 0, 0};
    tbl[6] = '{1,  50, 112, 2, 8, 1, 0,  50, 111, 0, 0};
    tbl[7] = '{1,  50, 112, 2, 8, 1, 1,  50, 112, 0, 0};
    tbl[8] = '{1,  50,   0, 2, 8, 1, 0,  50,   0, 0, 0};
    tbl[9] = '{1,  50,  40, 3, 4, 0, 1,  50,  41, 0, 0};

    tick(2);
    check("rst_plot", int'(plot), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_x", int'(x_out), 0);
    check("rst_y", int'(y_out), 0);
    check("rst_colour", int'(colour_out), 0);
    check("rst_hits", int'({hit_l, hit_r}), 0);

    for (int i = 0; i < 10; i++) begin
      do_reset();
      set_slot(0, 1, tbl[i].mode, tbl[i].w, tbl[i].h, 5);
      btn_up[0] = (tbl[i].up != 0);
      btn_dn[0] = (tbl[i].dn != 0);
      load(0, tbl[i].x, tbl[i].y);
      push_rect(tbl[i].x, tbl[i].y, tbl[i].w, tbl[i].h, 0);
      push_rect(tbl[i].ex, tbl[i].ey, tbl[i].w, tbl[i].h, 5);
      run_frame();
      check($sformatf("vec%0d_hit_l", i), hitl_cnt[0], tbl[i].hl);
      check($sformatf("vec%0d_hit_r", i), hitr_cnt[0], tbl[i].hr);
    end

    // Right wall, reversal, then left wall.
    do_reset();
    set_slot(0, 1, 0, 4, 2, 6);
    load(0, 156, 20);
    push_rect(156, 20, 4, 2, 0); push_rect(156, 21, 4, 2, 6);
    run_frame();
    check("wall_hit_r_f1", hitr_cnt[0], 1);
    push_rect(156, 21, 4, 2, 0); push_rect(155, 22, 4, 2, 6);
    run_frame();
    check("wall_hit_r_f2", hitr_cnt[0], 1);
    load(0, 0, 50);
    push_rect(0, 50, 4, 2, 0); push_rect(0, 51, 4, 2, 6);
    run_frame();
    check("wall_hit_l_f3", hitl_cnt[0], 1);
    push_rect(0, 51, 4, 2, 0); push_rect(1, 52, 4, 2, 6);
    run_frame();
    check("wall_hit_l_f4", hitl_cnt[0], 1);

    // Random stalls, disabled middle slot, load pending while busy.
    do_reset();
    set_slot(0, 1, 0, 3, 2, 3);
    set_slot(1, 0, 0, 2, 2, 4);
    set_slot(2, 1, 0, 2, 3, 7);
    load(0, 20, 30); load(1, 5, 5); load(2, 40, 60);
    rand_ready = 1'b1;
    push_rect(20, 30, 3, 2, 0); push_rect(21, 31, 3, 2, 3);
    push_rect(40, 60, 2, 3, 0); push_rect(41, 61, 2, 3, 7);
    run_frame();
    check("stall_accept_count", acc_cnt, 24);
    check("frame_done_lag", fd_cyc - last_acc_cyc, 1);
    push_rect(21, 31, 3, 2, 0); push_rect(100, 30, 3, 2, 3);
    push_rect(41, 61, 2, 3, 0); push_rect(42, 62, 2, 3, 7);
    run_frame(0, 100, 30);
    check("pend_accept_count", acc_cnt, 24);
    check("frame_done_lag2", fd_cyc - last_acc_cyc, 1);
    rand_ready = 1'b0;
    pix_ready = 1'b1;

    // Reset during DRAW aborts the pass at once.
    do_reset();
    set_slot(0, 1, 0, 4, 4, 2);
    load(0, 30, 30);
    push_rect(30, 30, 4, 4, 0); push_rect(31, 31, 4, 4, 2);
    run = 1'b1; tick(1); run = 1'b0;
    for (int k = 0; k < 200 && !(plot && colour_out == 3'd2); k++) tick(1);
    check("reached_draw", int'(plot && colour_out == 3'd2), 1);
    resetn = 1'b0;
    #1;
    check("abort_plot", int'(plot), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_x", int'(x_out), 0);
    exp_q.delete();
    tick(1);
    resetn = 1'b1;
    tick(10);
    check("post_rst_idle", int'(busy), 0);
    check("post_rst_plot", int'(plot), 0);
    push_rect(0, 0, 4, 4, 0); push_rect(1, 1, 4, 4, 2);
    run_frame();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
